unit_sel_encoder: RTL and testbench

//   Reverse of the ALU unit-select decoder. Takes one-hot "unit done" flags plus the result

---
 rtl/unit_sel_encoder_if.sv | 27 ++
 rtl/unit_sel_encoder.sv | 128 ++++++++++++
 tb/tb_unit_sel_encoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/unit_sel_encoder_if.sv
// Handshake bundle between the ALU sub-units, the unit-select encoder and write-back.
// Input side (in_*) is a valid/ready push port; output side (out_*) is a valid/ready pop port.
interface unit_sel_encoder_if #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = 16
);
  logic              in_vld;
  logic [N_IN-1:0]   in_onehot;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              out_vld;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              out_rdy;

  modport master (
    output in_vld, in_onehot, in_data, out_rdy,
    input  in_rdy, out_vld, out_id, out_data, out_err
  );

  modport slave (
    input  in_vld, in_onehot, in_data, out_rdy,
    output in_rdy, out_vld, out_id, out_data, out_err
  );
endinterface

// File: rtl/unit_sel_encoder.sv
// Encodes one-hot sub-unit done flags into a binary unit ID and queues {id, data, err}
// in a 2-entry buffer toward write-back; also counts accepted malformed flag vectors.
module unit_sel_encoder #(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unit_sel_encoder_if.slave    bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                 state_q, state_d;
  entry_t                 head_q, head_d;
  entry_t                 tail_q, tail_d;
  logic                   out_vld_q, out_vld_d;
  logic                   in_rdy_q, in_rdy_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  entry_t                 enc_c;
  logic                   push_c, pop_c;

  assign push_c = bus.in_vld && in_rdy_q;
  assign pop_c  = out_vld_q && bus.out_rdy;

  // Priority encoder: lowest set bit wins; anything but exactly one bit flags an error.
  always_comb begin
    logic found;
    logic multi;
    found      = 1'b0;
    multi      = 1'b0;
    enc_c.id   = '0;
    enc_c.data = bus.in_data;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (bus.in_onehot[i]) begin
        if (!found) begin
          enc_c.id = ID_W'(i);
          found    = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
    end
    enc_c.err = !found || multi;
  end

  // Occupancy FSM; head_q is always the presented entry, cleared when the buffer drains.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (push_c) begin
          head_d  = enc_c;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({push_c, pop_c})
          2'b10: begin
            tail_d  = enc_c;
            state_d = FULL;
          end
          2'b01: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          2'b11:   head_d = enc_c;
          default: ;
        endcase
      end
      FULL: begin
        if (pop_c) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
    if (push_c && enc_c.err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    out_vld_d = (state_d != EMPTY);
    in_rdy_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_rdy   = in_rdy_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_id   = head_q.id;
  assign bus.out_data = head_q.data;
  assign bus.out_err  = head_q.err;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_unit_sel_encoder.sv
// Scoreboard bench for unit_sel_encoder: directed scenarios plus random traffic,
// with a negedge monitor popping expected entries as the DUT presents them.
module tb_unit_sel_encoder;
  localparam int unsigned N_IN   = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unit_sel_encoder_if #(.N_IN(N_IN), .ID_W(ID_W), .DATA_W(DATA_W)) bus1 ();
  unit_sel_encoder_if #(.N_IN(N_IN), .ID_W(ID_W), .DATA_W(DATA_W)) bus2 ();
  logic [7:0] err_cnt1;
  logic [1:0] err_cnt2;

  unit_sel_encoder #(.N_IN(N_IN), .ID_W(ID_W), .DATA_W(DATA_W), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .err_cnt(err_cnt1));

  unit_sel_encoder #(.N_IN(N_IN), .ID_W(ID_W), .DATA_W(DATA_W), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .err_cnt(err_cnt2));

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: count the set flags, isolate the lowest one arithmetically, then find its index.
  function automatic exp_t model(input logic [N_IN-1:0] oh, input logic [DATA_W-1:0] d);
    exp_t e;
    int n;
    logic [N_IN-1:0] low;
    n = $countones(oh);
    low = oh & (~oh + N_IN'(1));
    e.data = d;
    e.err = (n != 1);
    e.id = '0;
    for (int k = 0; k < int'(N_IN); k++)
      if (low == (N_IN'(1) << k)) e.id = ID_W'(k);
    return e;
  endfunction

  // Monitor: pops on every handshake, checks hold-while-stalled and zeroed idle fields.
  exp_t mon_e;
  logic held_vld = 1'b0;
  logic [ID_W-1:0] held_id;
  logic [DATA_W-1:0] held_data;
  logic held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else if (bus1.out_vld) begin
      if (held_vld) begin
        chk("hold_id", 32'(bus1.out_id), 32'(held_id));
        chk("hold_data", 32'(bus1.out_data), 32'(held_data));
        chk("hold_err", 32'(bus1.out_err), 32'(held_err));
      end
      if (bus1.out_rdy) begin
        held_vld = 1'b0;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got id=%0d data=%0h with no entry expected", bus1.out_id, bus1.out_data);
        end else begin
          mon_e = sb.pop_front();
          if (bus1.out_id !== mon_e.id || bus1.out_data !== mon_e.data || bus1.out_err !== mon_e.err) begin
            bad++;
            $display("FAIL out_entry: got id=%0d data=%0h err=%0b expected id=%0d data=%0h err=%0b",
                     bus1.out_id, bus1.out_data, bus1.out_err, mon_e.id, mon_e.data, mon_e.err);
          end
        end
      end else begin
        held_vld = 1'b1;
        held_id = bus1.out_id;
        held_data = bus1.out_data;
        held_err = bus1.out_err;
      end
    end else begin
      held_vld = 1'b0;
      chk("idle_fields", {13'd0, bus1.out_id, bus1.out_data, bus1.out_err}, 32'd0);
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic vld, input logic [N_IN-1:0] oh, input logic [DATA_W-1:0] d,
                      input logic ordy, output logic acc);
    exp_t e;
    bus1.in_vld = vld;
    bus1.in_onehot = vld ? oh : 'x;
    bus1.in_data = vld ? d : 'x;
    bus1.out_rdy = ordy;
    @(negedge clk);
    chk("err_cnt", 32'(err_cnt1), 32'(exp_err));
    acc = vld && bus1.in_rdy;
    if (acc) begin
      e = model(oh, d);
      sb.push_back(e);
      if (e.err && exp_err < 255) exp_err++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, a);
  endtask

  logic acc;
  logic [N_IN-1:0] roh;

  initial begin
    bus1.in_vld = 1'b0; bus1.in_onehot = '0; bus1.in_data = '0; bus1.out_rdy = 1'b0;
    bus2.in_vld = 1'b0; bus2.in_onehot = '0; bus2.in_data = '0; bus2.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", 32'(bus1.out_vld), 0);
    chk("rst_err_cnt", 32'(err_cnt1), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(bus1.in_rdy), 1);

    // Single entry, one-cycle latency.
    step(1'b1, 4'b0100, 16'h00a5, 1'b1, acc);
    chk("t1_acc", 32'(acc), 1);
    chk("t1_vld", 32'(bus1.out_vld), 1);
    chk("t1_id", 32'(bus1.out_id), 2);
    chk("t1_data", 32'(bus1.out_data), 32'h00a5);
    chk("t1_err", 32'(bus1.out_err), 0);
    idle(1);

    // Fill to FULL under backpressure; third push refused.
    step(1'b1, 4'b0001, 16'h1111, 1'b0, acc);
    chk("t2_acc0", 32'(acc), 1);
    step(1'b1, 4'b1000, 16'h2222, 1'b0, acc);
    chk("t2_acc1", 32'(acc), 1);
    step(1'b1, 4'b0010, 16'h3333, 1'b0, acc);
    chk("t2_acc2", 32'(acc), 0);
    chk("t2_full_rdy", 32'(bus1.in_rdy), 0);
    step(1'b0, '0, '0, 1'b1, acc);
    chk("t2_rdy_after_pop", 32'(bus1.in_rdy), 1);
    idle(2);

    // Malformed flag vectors.
    step(1'b1, 4'b0110, 16'h4444, 1'b1, acc);
    step(1'b1, 4'b0000, 16'h5555, 1'b1, acc);
    idle(2);
    chk("t3_err_cnt", 32'(err_cnt1), 2);

    // Back-to-back streaming through state ONE.
    step(1'b1, 4'b0010, 16'h6000, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0010, 16'(16'h6001 + i), 1'b1, acc);
      chk("t4_acc", 32'(acc), 1);
      chk("t4_vld", 32'(bus1.out_vld), 1);
      chk("t4_id", 32'(bus1.out_id), 1);
    end
    idle(2);

    // Saturating counter on the narrow instance.
    bus2.in_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus2.in_onehot = (k % 2 == 0) ? 4'b1010 : 4'b0000;
      bus2.in_data = 16'(k);
      @(posedge clk);
      #1;
      chk("t6_sat_cnt", 32'(err_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    bus2.in_vld = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      roh = ($urandom_range(0, 9) < 7) ? (N_IN'(1) << $urandom_range(0, N_IN - 1)) : N_IN'($urandom);
      step($urandom_range(0, 3) != 0, roh, 16'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("drain_empty", 32'(sb.size()), 0);

    // Async reset while FULL.
    step(1'b1, 4'b0000, 16'h7777, 1'b0, acc);
    step(1'b1, 4'b0011, 16'h8888, 1'b0, acc);
    chk("t5_full", 32'(bus1.in_rdy), 0);
    bus1.in_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_vld_drop", 32'(bus1.out_vld), 0);
    chk("t5_cnt_drop", 32'(err_cnt1), 0);
    sb.delete();
    exp_err = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_rdy", 32'(bus1.in_rdy), 1);
    idle(3);
    chk("t5_no_stale", 32'(bus1.out_vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
